vga_timing_gen: RTL and testbench

- Produces the raster scan position (DrawX, DrawY), the active-video qualifier (blank), and the sync pulses (hs, vs) for a 640x480 @ 60 Hz display.
- Drives the sprite/background renderers; those consume DrawX/DrawY/blank on vga_clk and register their colour outputs.
- Optional DELAY stages retime hs/vs/blank/frame_start so they stay aligned with renderer pipeline latency (ROM read plus colour register).
- Also provides per-line and per-frame strobes plus a free-running frame counter for animation timing.

---
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_if
//  Brief    : Raster position, qualifier and sync bundle produced by
//             vga_timing_gen and consumed by the renderers.
//  Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;

    // Timing generator side
    modport master (
        output DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    );

    // Renderer side
    modport slave (
        input DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Brief    : 640x480@60 raster timing: scan position, active-video blank,
//             active-low hs/vs, line/frame strobes and a frame counter.
//             Decoded signals can be retimed by DELAY extra flops so they stay
//             aligned with the renderer pipeline; DrawX/DrawY are never delayed.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int DELAY     = 2
) (
    input  wire              vga_clk,
    input  wire              reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Bit positions of the decoded signals inside one delay-chain stage
    localparam int B_HS = 4;
    localparam int B_VS = 3;
    localparam int B_BL = 2;
    localparam int B_LS = 1;
    localparam int B_FS = 0;

    // Idle value of a stage: syncs deasserted (high), everything else low
    localparam logic [4:0] SYNC_IDLE = 5'b11000;

    // Counters are 10 bits wide and the chain depth is capped at 7
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must each be <= 1024");
        end
        if (DELAY < 0 || DELAY > 7) begin : g_bad_delay
            $error("vga_timing_gen: DELAY must be in 0..7");
        end
    endgenerate

    logic [9:0]            x_q, x_d;
    logic [9:0]            y_q, y_d;
    logic [7:0]            frame_count_q, frame_count_d;
    // Stage 0 is the decode register; stages 1..DELAY are pure retiming
    logic [DELAY:0][4:0]   sync_q, sync_d;

    // Raster counters: X wraps each line, Y wraps each frame, frame counter
    // advances on the edge that lands on (0,0)
    always_comb begin
        x_d           = x_q + 10'd1;
        y_d           = y_q;
        frame_count_d = frame_count_q;
        if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
                y_d           = '0;
                frame_count_d = frame_count_q + 8'd1;
            end else begin
                y_d = y_q + 10'd1;
            end
        end
    end

    // Decode from the next counter values so stage 0 lines up with DrawX/DrawY,
    // then shift each stage one flop further down the chain
    always_comb begin
        sync_d          = sync_q;
        sync_d[0][B_HS] = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        sync_d[0][B_VS] = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        sync_d[0][B_BL] = (x_d < H_VIS) && (y_d < V_VIS);
        sync_d[0][B_LS] = (x_d == 10'd0);
        sync_d[0][B_FS] = (x_d == 10'd0) && (y_d == 10'd0);
        for (int i = 1; i <= DELAY; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // State register; reset clears the whole chain so no pulse survives it
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            frame_count_q <= '0;
            sync_q        <= {(DELAY+1){SYNC_IDLE}};
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            frame_count_q <= frame_count_d;
            sync_q        <= sync_d;
        end
    end

    assign vga.DrawX       = x_q;
    assign vga.DrawY       = y_q;
    assign vga.frame_count = frame_count_q;
    assign vga.hs          = sync_q[DELAY][B_HS];
    assign vga.vs          = sync_q[DELAY][B_VS];
    assign vga.blank       = sync_q[DELAY][B_BL];
    assign vga.line_start  = sync_q[DELAY][B_LS];
    assign vga.frame_start = sync_q[DELAY][B_FS];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Brief    : Self-checking bench for vga_timing_gen. Four instances share one
//             clock/reset: full 640x480 timing with DELAY 0 and 2, and a tiny
//             16x9 raster with DELAY 0 and 2 for frame-level behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        int hv, hf, hsn, hb, vv, vf, vsn, vb, d;
    } cfg_t;

    // One table record: instance and cycle index in, expected outputs out
    typedef struct {
        int   id;
        int   k;
        obs_t e;
    } vec_t;

    typedef struct {
        int   id;
        obs_t e;
    } sb_t;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();
    vga_timing_gen_if if_d ();

    vga_timing_gen #(.DELAY(0)) u_a (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_a));
    vga_timing_gen #(.DELAY(2)) u_b (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_b));
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .DELAY(0)
    ) u_c (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_c));
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .DELAY(2)
    ) u_d (.vga_clk(vga_clk), .reset_n(reset_n), .vga(if_d));

    always #5 vga_clk = ~vga_clk;

    cfg_t cfg [4];
    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   k     = 0;
    int   phase = 0;
    int   hs_low_a, vs_low_c, fs_c, stray_fs;

    // Reference: position after kk edges, decode of position kk-d (reset values before 1)
    function automatic obs_t model(cfg_t c, int kk);
        obs_t m;
        int ht, vt, kd, xd, yd, hs0, vs0;
        ht   = c.hv + c.hf + c.hsn + c.hb;
        vt   = c.vv + c.vf + c.vsn + c.vb;
        m.x  = 10'(kk % ht);
        m.y  = 10'((kk / ht) % vt);
        m.fc = 8'((kk / (ht * vt)) % 256);
        m.hs = 1'b1; m.vs = 1'b1; m.bl = 1'b0; m.ls = 1'b0; m.fs = 1'b0;
        kd   = kk - c.d;
        if (kd >= 1) begin
            xd   = kd % ht;
            yd   = (kd / ht) % vt;
            hs0  = c.hv + c.hf;
            vs0  = c.vv + c.vf;
            m.hs = !(xd >= hs0 && xd < hs0 + c.hsn);
            m.vs = !(yd >= vs0 && yd < vs0 + c.vsn);
            m.bl = (xd < c.hv) && (yd < c.vv);
            m.ls = (xd == 0);
            m.fs = (xd == 0) && (yd == 0);
        end
        return m;
    endfunction

    function automatic obs_t sample(int id);
        obs_t s;
        case (id)
            0: s = '{if_a.DrawX, if_a.DrawY, if_a.hs, if_a.vs, if_a.blank, if_a.line_start, if_a.frame_start, if_a.frame_count};
            1: s = '{if_b.DrawX, if_b.DrawY, if_b.hs, if_b.vs, if_b.blank, if_b.line_start, if_b.frame_start, if_b.frame_count};
            2: s = '{if_c.DrawX, if_c.DrawY, if_c.hs, if_c.vs, if_c.blank, if_c.line_start, if_c.frame_start, if_c.frame_count};
            default: s = '{if_d.DrawX, if_d.DrawY, if_d.hs, if_d.vs, if_d.blank, if_d.line_start, if_d.frame_start, if_d.frame_count};
        endcase
        return s;
    endfunction

    task automatic check(string tag, int id, obs_t e);
        obs_t a;
        a = sample(id);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s inst%0d k=%0d: got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d",
                     tag, id, k, a.x, a.y, a.hs, a.vs, a.bl, a.ls, a.fs, a.fc,
                     e.x, e.y, e.hs, e.vs, e.bl, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic check_count(string tag, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic add(int id, int kk, int x, int y, bit hs, bit vs, bit bl, bit ls, bit fs, int fc);
        vec_t v;
        v.id   = id;
        v.k    = kk;
        v.e.x  = 10'(x);
        v.e.y  = 10'(y);
        v.e.hs = hs; v.e.vs = vs; v.e.bl = bl; v.e.ls = ls; v.e.fs = fs;
        v.e.fc = 8'(fc);
        vecs.push_back(v);
    endtask

    // One clock: predictions queued at the edge, popped and compared mid-cycle
    task automatic step();
        sb_t s;
        @(posedge vga_clk);
        k++;
        for (int id = 0; id < 4; id++) begin
            s.id = id;
            s.e  = model(cfg[id], k);
            sb_q.push_back(s);
        end
        @(negedge vga_clk);
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            check("scoreboard", s.id, s.e);
        end
        if (phase == 0) begin
            for (int i = 0; i < vecs.size(); i++) begin
                if (vecs[i].k == k) check("table", vecs[i].id, vecs[i].e);
            end
            if (k <= 800 && if_a.hs == 1'b0) hs_low_a++;
            if (k <= 144 && if_c.vs == 1'b0) vs_low_c++;
            if (k <= 36864 && if_c.frame_start) fs_c++;
        end else begin
            if (if_a.frame_start || if_b.frame_start) stray_fs++;
        end
    endtask

    initial begin
        bit found;
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
        cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
        cfg[2] = '{8, 2, 3, 3, 4, 1, 2, 2, 0};
        cfg[3] = '{8, 2, 3, 3, 4, 1, 2, 2, 2};
        hs_low_a = 0; vs_low_c = 0; fs_c = 0; stray_fs = 0;

        //   id  k       x    y   hs vs bl ls fs fc
        add(0, 1,       1,   0,  1, 1, 1, 0, 0, 0);
        add(0, 639,     639, 0,  1, 1, 1, 0, 0, 0);
        add(0, 640,     640, 0,  1, 1, 0, 0, 0, 0);
        add(0, 655,     655, 0,  1, 1, 0, 0, 0, 0);
        add(0, 656,     656, 0,  0, 1, 0, 0, 0, 0);
        add(0, 751,     751, 0,  0, 1, 0, 0, 0, 0);
        add(0, 752,     752, 0,  1, 1, 0, 0, 0, 0);
        add(0, 800,     0,   1,  1, 1, 1, 1, 0, 0);
        add(0, 801,     1,   1,  1, 1, 1, 0, 0, 0);
        add(1, 2,       2,   0,  1, 1, 0, 0, 0, 0);
        add(1, 3,       3,   0,  1, 1, 1, 0, 0, 0);
        add(1, 641,     641, 0,  1, 1, 1, 0, 0, 0);
        add(1, 642,     642, 0,  1, 1, 0, 0, 0, 0);
        add(1, 657,     657, 0,  1, 1, 0, 0, 0, 0);
        add(1, 658,     658, 0,  0, 1, 0, 0, 0, 0);
        add(1, 753,     753, 0,  0, 1, 0, 0, 0, 0);
        add(1, 754,     754, 0,  1, 1, 0, 0, 0, 0);
        add(1, 801,     1,   1,  1, 1, 0, 0, 0, 0);
        add(1, 802,     2,   1,  1, 1, 1, 1, 0, 0);
        add(2, 9,       9,   0,  1, 1, 0, 0, 0, 0);
        add(2, 10,      10,  0,  0, 1, 0, 0, 0, 0);
        add(2, 12,      12,  0,  0, 1, 0, 0, 0, 0);
        add(2, 13,      13,  0,  1, 1, 0, 0, 0, 0);
        add(2, 55,      7,   3,  1, 1, 1, 0, 0, 0);
        add(2, 56,      8,   3,  1, 1, 0, 0, 0, 0);
        add(2, 64,      0,   4,  1, 1, 0, 1, 0, 0);
        add(2, 79,      15,  4,  1, 1, 0, 0, 0, 0);
        add(2, 80,      0,   5,  1, 0, 0, 1, 0, 0);
        add(2, 111,     15,  6,  1, 0, 0, 0, 0, 0);
        add(2, 112,     0,   7,  1, 1, 0, 1, 0, 0);
        add(2, 143,     15,  8,  1, 1, 0, 0, 0, 0);
        add(2, 144,     0,   0,  1, 1, 1, 1, 1, 1);
        add(2, 288,     0,   0,  1, 1, 1, 1, 1, 2);
        add(2, 36863,   15,  8,  1, 1, 0, 0, 0, 255);
        add(2, 36864,   0,   0,  1, 1, 1, 1, 1, 0);
        add(3, 11,      11,  0,  1, 1, 0, 0, 0, 0);
        add(3, 12,      12,  0,  0, 1, 0, 0, 0, 0);
        add(3, 145,     1,   0,  1, 1, 0, 0, 0, 1);
        add(3, 146,     2,   0,  1, 1, 1, 1, 1, 1);
        add(3, 147,     3,   0,  1, 1, 1, 0, 0, 1);

        // Power-on reset held for 5 cycles
        reset_n = 1'b0;
        repeat (5) begin
            @(negedge vga_clk);
            for (int id = 0; id < 4; id++) check("reset", id, model(cfg[id], 0));
        end
        reset_n = 1'b1;

        // Line, frame, delay and 256-frame wrap run
        repeat (36870) step();
        check_count("hs_low_cycles_line0", hs_low_a, 96);
        check_count("vs_low_cycles_frame0", vs_low_c, 32);
        check_count("frame_start_count_256_frames", fs_c, 256);

        // Reach DrawX=700 on the full-size raster, inside the hs pulse
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            step();
            if (if_a.DrawX == 10'd700) found = 1'b1;
        end
        check_count("reach_drawx_700", int'(found), 1);

        // Asynchronous reset between edges takes effect before the next edge
        #2 reset_n = 1'b0;
        #1;
        for (int id = 0; id < 4; id++) check("async_reset", id, model(cfg[id], 0));
        repeat (3) begin
            @(negedge vga_clk);
            for (int id = 0; id < 4; id++) check("reset_hold", id, model(cfg[id], 0));
        end
        reset_n = 1'b1;
        k       = 0;
        phase   = 1;
        repeat (1000) step();
        check_count("stray_frame_start_after_reset", stray_fs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
